// File: rtl/count_event_monitor.sv
// Observer for a loadable up/down counter: classifies each sampled transition,
// keeps sticky status, a saturating wrap tally, last direction and a maskable irq.
module count_event_monitor #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cnt_in,
    input  logic [N-1:0] hi_thr,
    input  logic [N-1:0] lo_thr,
    input  logic         clr,
    input  logic [4:0]   irq_mask,
    output logic [4:0]   status,
    output logic [W-1:0] wrap_cnt,
    output logic         dir,
    output logic         evt_valid,
    output logic         irq
);

    localparam logic [N-1:0] CNT_MAX  = '1;
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] WRAP_MAX = '1;
    localparam logic [W-1:0] WRAP_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [N-1:0] prev_q;
    logic         prev_vld;
    logic [N-1:0] delta;
    logic         hold, up_wrap, dn_wrap, up_step, dn_step, jump;
    logic         hi_hit, lo_hit;
    logic [4:0]   status_set, status_nxt;
    logic [W-1:0] wrap_base, wrap_nxt;
    logic         dir_nxt;

    always_comb begin
        delta   = cnt_in - prev_q;
        hold    = (delta == '0);
        up_wrap = (prev_q == CNT_MAX) && (cnt_in == '0);
        dn_wrap = (prev_q == '0) && (cnt_in == CNT_MAX);
        // A wrap also has delta of +/-1, so steps exclude the wrap cases.
        up_step = !up_wrap && (delta == CNT_ONE);
        dn_step = !dn_wrap && (delta == CNT_MAX);
        jump    = !hold && !up_wrap && !dn_wrap && !up_step && !dn_step;
        hi_hit  = (prev_q < hi_thr) && (cnt_in >= hi_thr);
        lo_hit  = (prev_q > lo_thr) && (cnt_in <= lo_thr);

        status_set = {lo_hit, hi_hit, jump, dn_wrap, up_wrap} & {5{prev_vld}};
        // Clear first, then OR in this cycle's events so a same-cycle event survives clr.
        status_nxt = (clr ? 5'b0 : status) | status_set;

        wrap_base = clr ? '0 : wrap_cnt;
        wrap_nxt  = wrap_base;
        if (prev_vld && (up_wrap || dn_wrap) && (wrap_base != WRAP_MAX))
            wrap_nxt = wrap_base + WRAP_ONE;

        dir_nxt = dir;
        if (prev_vld && (up_wrap || up_step))
            dir_nxt = 1'b1;
        else if (prev_vld && (dn_wrap || dn_step))
            dir_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q    <= '0;
            prev_vld  <= 1'b0;
            status    <= '0;
            wrap_cnt  <= '0;
            dir       <= 1'b1;
            evt_valid <= 1'b0;
            irq       <= 1'b0;
        end else begin
            prev_q    <= cnt_in;
            prev_vld  <= 1'b1;
            status    <= status_nxt;
            wrap_cnt  <= wrap_nxt;
            dir       <= dir_nxt;
            evt_valid <= prev_vld && !hold;
            irq       <= |(status_nxt & irq_mask);
        end
    end

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: two instances (W=8 and W=2) share stimulus and
// are compared against an arithmetic reference model of the classification rules.
module tb_count_event_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cnt_in = 4'h0;
    logic [3:0] hi_thr = 4'h0;
    logic [3:0] lo_thr = 4'hF;
    logic       clr = 1'b0;
    logic [4:0] irq_mask = 5'h0;

    logic [4:0] st8, st2;
    logic [7:0] wc8;
    logic [1:0] wc2;
    logic       dir8, dir2, ev8, ev2, irq8, irq2;

    count_event_monitor #(.N(4), .W(8)) u_dut8 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .hi_thr(hi_thr), .lo_thr(lo_thr),
        .clr(clr), .irq_mask(irq_mask), .status(st8), .wrap_cnt(wc8),
        .dir(dir8), .evt_valid(ev8), .irq(irq8));

    count_event_monitor #(.N(4), .W(2)) u_dut2 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .hi_thr(hi_thr), .lo_thr(lo_thr),
        .clr(clr), .irq_mask(irq_mask), .status(st2), .wrap_cnt(wc2),
        .dir(dir2), .evt_valid(ev2), .irq(irq2));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int         m_prev;
    bit         m_vld;
    logic [4:0] m_st;
    int         m_w8, m_w2;
    logic       m_dir, m_evt, m_irq;

    function automatic logic [25:0] obs();
        return {st8, st2, wc8, wc2, dir8, dir2, ev8, ev2, irq8, irq2};
    endfunction

    function automatic logic [25:0] exp_v();
        return {m_st, m_st, 8'(m_w8), 2'(m_w2), m_dir, m_dir, m_evt, m_evt, m_irq, m_irq};
    endfunction

    task automatic model_reset();
        m_prev = 0; m_vld = 0; m_st = '0; m_w8 = 0; m_w2 = 0;
        m_dir = 1'b1; m_evt = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        int c, d, hi, lo;
        bit uw, dw;
        c = int'(cnt_in); hi = int'(hi_thr); lo = int'(lo_thr);
        if (clr) begin m_st = '0; m_w8 = 0; m_w2 = 0; end
        if (!m_vld) begin
            m_evt = 1'b0;
        end else begin
            d  = (c - m_prev + 16) % 16;
            uw = (m_prev == 15) && (c == 0);
            dw = (m_prev == 0) && (c == 15);
            m_evt = (d != 0);
            if (uw)           begin m_st[0] = 1'b1; m_dir = 1'b1; end
            else if (dw)      begin m_st[1] = 1'b1; m_dir = 1'b0; end
            else if (d == 1)  m_dir = 1'b1;
            else if (d == 15) m_dir = 1'b0;
            else if (d != 0)  m_st[2] = 1'b1;
            if (uw || dw) begin
                if (m_w8 < 255) m_w8++;
                if (m_w2 < 3)   m_w2++;
            end
            if (m_prev < hi && c >= hi) m_st[3] = 1'b1;
            if (m_prev > lo && c <= lo) m_st[4] = 1'b1;
        end
        m_irq  = |(m_st & irq_mask);
        m_prev = c;
        m_vld  = 1'b1;
    endtask

    task automatic step(input logic [3:0] v, input logic c);
        @(negedge clk);
        cnt_in = v;
        clr    = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; cnt_in = 4'h9; model_reset();
        #12;
        checks++;
        if ({st8, wc8, dir8, ev8, irq8} !== {5'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got %h want %h", {st8, wc8, dir8, ev8, irq8}, {5'b0, 8'd0, 3'b100});
        end
        @(posedge clk); #2; rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'h9, 1'b0);
            checks++;
            if (obs() !== exp_v() || ev8 !== 1'b0 || st8 !== 5'b0 || dir8 !== 1'b1) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, obs(), exp_v());
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] seq [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        for (int i = 0; i < 8; i++) begin
            step(seq[i], 1'b0);
            checks++;
            if (obs() !== exp_v() || ev8 !== 1'b1) begin
                failures++;
                $display("FAIL up_ramp[%0d]: got %h want %h", i, obs(), exp_v());
            end
        end
        checks++;
        if ({st8, wc8, dir8} !== {5'b00001, 8'd1, 1'b1}) begin
            failures++;
            $display("FAIL up_wrap_summary: got %h want %h", {st8, wc8, dir8}, {5'b00001, 8'd1, 1'b1});
        end
    endtask

    task automatic test_dn_wrap();
        logic [3:0] seq [4] = '{4'h1, 4'h0, 4'hF, 4'hE};
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1'b0);
            checks++;
            if (obs() !== exp_v()) begin
                failures++;
                $display("FAIL dn_ramp[%0d]: got %h want %h", i, obs(), exp_v());
            end
        end
        checks++;
        if ({st8[1], dir8, wc8} !== {1'b1, 1'b0, 8'd2}) begin
            failures++;
            $display("FAIL dn_wrap_summary: got %h want %h", {st8[1], dir8, wc8}, {2'b10, 8'd2});
        end
    endtask

    task automatic test_jump_thr();
        logic [4:0] masks [6] = '{5'h00, 5'h04, 5'h08, 5'h01, 5'h10, 5'h1F};
        logic       want_irq;
        hi_thr = 4'h8;
        for (int i = 0; i < 6; i++) begin
            irq_mask = masks[i];
            step(4'h3, 1'b0);
            step(4'h3, 1'b1);
            step(4'hA, 1'b0);
            want_irq = (masks[i] & 5'b01100) != 5'b0;
            checks++;
            if (obs() !== exp_v() || st8 !== 5'b01100 || irq8 !== want_irq) begin
                failures++;
                $display("FAIL jump_thr[mask=%h]: got %h want %h", masks[i], obs(), exp_v());
            end
        end
        irq_mask = 5'h00;
    endtask

    task automatic test_saturation_clr();
        step(4'hA, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'h8, 1'b0);
            step(4'hF, 1'b0);
            step(4'h0, 1'b0);
            checks++;
            if (obs() !== exp_v()) begin
                failures++;
                $display("FAIL sat_wrap[%0d]: got %h want %h", i, obs(), exp_v());
            end
        end
        checks++;
        if ({wc2, wc8, st8[0]} !== {2'b11, 8'd5, 1'b1}) begin
            failures++;
            $display("FAIL sat_level: got %h want %h", {wc2, wc8, st8[0]}, {2'b11, 8'd5, 1'b1});
        end
        step(4'h8, 1'b0);
        step(4'hF, 1'b0);
        step(4'h0, 1'b1);
        checks++;
        if (obs() !== exp_v() || {wc2, wc8, st8} !== {2'd1, 8'd1, 5'b00001}) begin
            failures++;
            $display("FAIL clr_with_wrap: got %h want %h", obs(), exp_v());
        end
    endtask

    task automatic test_mid_reset();
        hi_thr = 4'h0; lo_thr = 4'hF;
        step(4'h4, 1'b0);
        step(4'h5, 1'b0);
        step(4'h6, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0; model_reset();
        #1;
        checks++;
        if (obs() !== exp_v() || {st8, wc8, dir8, ev8, irq8} !== {5'b0, 8'd0, 3'b100}) begin
            failures++;
            $display("FAIL mid_reset: got %h want %h", obs(), exp_v());
        end
        cnt_in = 4'hC;
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(4'hC, 1'b0);
            checks++;
            if (obs() !== exp_v() || ev8 !== 1'b0 || st8 !== 5'b0 || dir8 !== 1'b1) begin
                failures++;
                $display("FAIL post_reset[%0d]: got %h want %h", i, obs(), exp_v());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        int r;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                hi_thr   = 4'($urandom_range(0, 15));
                lo_thr   = 4'($urandom_range(0, 15));
                irq_mask = 5'($urandom_range(0, 31));
            end
            r = $urandom_range(0, 9);
            v = cnt_in;
            if (r >= 3 && r <= 5)      v = cnt_in + 4'h1;
            else if (r >= 6 && r <= 8) v = cnt_in - 4'h1;
            else if (r == 9)           v = 4'($urandom_range(0, 15));
            step(v, $urandom_range(0, 7) == 0);
            checks++;
            if (obs() !== exp_v()) begin
                failures++;
                $display("FAIL random[%0d]: got %h want %h", i, obs(), exp_v());
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_dn_wrap();
        test_jump_thr();
        test_saturation_clr();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream observer for the team's N-bit loadable up/down counter. It samples the counter's output every clock and classifies each transition as hold, unit up-step, unit down-step, up-wrap, down-wrap or arbitrary jump (load).
- It keeps sticky status bits, a saturating wrap tally, the last-seen direction, and threshold-crossing detection, and raises a maskable interrupt level for the system controller.

Parameters:
- N, 4, width of the monitored count; legal range N >= 2.
- W, 8, width of the saturating wrap tally.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- cnt_in  input  N  counter value; driven straight from the upstream counter's registered output.
- hi_thr  input  N  upper threshold, unsigned; treated as quasi-static.
- lo_thr  input  N  lower threshold, unsigned; treated as quasi-static.
- clr  input  1  synchronous clear of the sticky status bits and wrap_cnt.
- irq_mask  input  5  per-bit enable of status into irq; bit order matches status.
- status  output  5  sticky bits: [0] up_wrap, [1] dn_wrap, [2] jump, [3] hi_hit, [4] lo_hit.
- wrap_cnt  output  W  count of up-wraps plus down-wraps; saturates at all-ones.
- dir  output  1  last non-hold unit-step direction: 1 = up, 0 = down.
- evt_valid  output  1  1-cycle pulse for any non-hold transition.
- irq  output  1  registered level equal to |(status & irq_mask).

Behaviour:
- Reset (rst low, asynchronous): prev_q = 0, prev_vld = 0, status = 0, wrap_cnt = 0, dir = 1, evt_valid = 0, irq = 0.
- First edge after reset release: captures cnt_in into prev_q, sets prev_vld, and produces no events.
- Every later edge: prev_q <= cnt_in. Classification is combinational on cnt_in vs prev_q; all results are registered.
- Latency: an event is visible exactly 1 clock after cnt_in shows the new value.
- Classification uses delta = (cnt_in - prev_q) mod 2^N:
  - delta == 0: hold. No event; evt_valid = 0.
  - prev_q == 2^N-1 and cnt_in == 0: up_wrap. Sets status[0], dir <= 1, wrap_cnt += 1.
  - prev_q == 0 and cnt_in == 2^N-1: dn_wrap. Sets status[1], dir <= 0, wrap_cnt += 1.
  - Otherwise delta == 1: up-step, dir <= 1.
  - Otherwise delta == 2^N-1: down-step, dir <= 0.
  - Anything else: jump. Sets status[2]; dir unchanged.
  - A load whose value equals prev_q±1 is indistinguishable from a step and is classified as a step by design.
- Threshold crossings (unsigned compare, only when prev_vld = 1):
  - hi_hit (status[3]) sets when prev_q < hi_thr and cnt_in >= hi_thr.
  - lo_hit (status[4]) sets when prev_q > lo_thr and cnt_in <= lo_thr.
  - Crossings are evaluated independently of classification, so a jump or wrap can also set hi_hit or lo_hit.
  - hi_thr = 0 never sets hi_hit. lo_thr = 2^N-1 never sets lo_hit.
- evt_valid = 1 for every non-hold classification.
- wrap_cnt saturates: it holds at 2^W-1 and further wraps do not roll it over.
- clr:
  - Clears status and wrap_cnt.
  - Same-cycle event wins: the bit set by that event ends up 1.
  - A wrap in the clr cycle leaves wrap_cnt = 1.
  - clr does not affect prev_q, dir or evt_valid.
- irq is registered from the next-state status, so it rises in the same cycle the sticky bit rises.
- Reset mid-operation clears all state immediately. The next edge after release is again a capture-only edge, so no spurious jump is reported.

Test Plan:
- Reset release with cnt_in = 4'h9, hold 3 cycles -> no evt_valid; status = 0; dir = 1.
- cnt_in ramps 4'hD,E,F,0,1 -> evt_valid on each step; single up_wrap (status = 5'b00001); wrap_cnt = 1; dir = 1.
- cnt_in 4'h1,0,F,E -> dn_wrap set (status[1]); dir = 0; wrap_cnt increments.
- cnt_in 4'h3 -> 4'hA with hi_thr = 8 -> status[2] and status[3] both set; irq = 1 only when irq_mask has bit 2 or 3 set.
- W = 2: drive 5 up-wraps -> wrap_cnt saturates at 2'b11. Then assert clr in the same cycle as a wrap -> wrap_cnt = 1 and status[0] = 1.
- Assert rst mid-ramp at cnt_in = 4'h6, release with cnt_in = 4'hC -> all outputs 0 (dir = 1); no jump reported on the first post-reset edge.
